// File: rtl/rom_download_router_if.sv
// rom_download_router_if
//   Bundles the hps_io ioctl download stream, the ROM-init write port and
//   the cartridge length status into one connection.
//   master : HPS / download side (drives ioctl_*, observes everything else)
//   slave  : the router (consumes ioctl_*, drives wait, rominit_* and cart_*)
interface rom_download_router_if;
  logic        ioctl_download;
  logic [7:0]  ioctl_index;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wait;

  logic        rominit_sel_boot;
  logic        rominit_sel_chr;
  logic        rominit_sel_cart;
  logic [16:0] rominit_addr;
  logic [7:0]  rominit_data;
  logic        rominit_valid;

  logic [17:0] cart_len;
  logic        cart_loaded;

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    input  ioctl_wait,
    input  rominit_sel_boot, rominit_sel_chr, rominit_sel_cart,
    input  rominit_addr, rominit_data, rominit_valid,
    input  cart_len, cart_loaded
  );

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    output ioctl_wait,
    output rominit_sel_boot, rominit_sel_chr, rominit_sel_cart,
    output rominit_addr, rominit_data, rominit_valid,
    output cart_len, cart_loaded
  );
endinterface

// File: rtl/rom_download_router.sv
// rom_download_router
//   Routes the hps_io download byte stream into boot, character or cartridge
//   ROM writes. Each accepted byte produces one registered, paced write pulse;
//   the HPS is held off with ioctl_wait while a write is in flight. Tracks the
//   cartridge length and a loaded flag for the mapper.
// Ports
//   clk_sys_i : system clock
//   reset_i   : synchronous active-high reset
//   bus_if    : slave side of rom_download_router_if (ioctl in, rominit/cart out)
//
// state | meaning
// IDLE  | ready for a byte; ioctl_wait low
// EMIT  | rominit_valid high for one cycle with target/address/data stable
// GAP   | WR_GAP idle cycles before the next byte may be taken
module rom_download_router #(
  parameter int WR_GAP     = 2,
  parameter int BOOT_BYTES = 4096,
  parameter int CHR_BYTES  = 1024,
  parameter int CART_BYTES = 131072
) (
  input  logic                 clk_sys_i,
  input  logic                 reset_i,
  rom_download_router_if.slave bus_if
);

  localparam logic [24:0] BOOT_LIM = 25'(BOOT_BYTES);
  localparam logic [24:0] CHR_LIM  = 25'(BOOT_BYTES + CHR_BYTES);
  localparam logic [24:0] CART_LIM = 25'(CART_BYTES);
  localparam logic [3:0]  GAP_LOAD = 4'((WR_GAP > 0) ? (WR_GAP - 1) : 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  gap_cnt_q, gap_cnt_d;
  logic [2:0]  sel_q, sel_d;          // {cart, chr, boot}
  logic [16:0] addr_q, addr_d;
  logic [7:0]  data_q, data_d;
  logic [17:0] acc_q, acc_d;
  logic [17:0] len_q, len_d;
  logic        loaded_q, loaded_d;
  logic        dl_q;
  logic        dl_cart_q, dl_cart_d;
  logic        commit_pend_q, commit_pend_d;

  logic [2:0]  hit_sel;
  logic [16:0] hit_addr;
  logic        accept;
  logic        dl_rise, dl_fall;
  logic [17:0] off_p1;

  // Target decode for the byte currently on the ioctl bus.
  always_comb begin
    hit_sel  = 3'b000;
    hit_addr = 17'd0;
    if (bus_if.ioctl_index == 8'd0) begin
      if (bus_if.ioctl_addr < BOOT_LIM) begin
        hit_sel  = 3'b001;
        hit_addr = 17'(bus_if.ioctl_addr);
      end else if (bus_if.ioctl_addr < CHR_LIM) begin
        hit_sel  = 3'b010;
        hit_addr = 17'(bus_if.ioctl_addr - BOOT_LIM);
      end
    end else if (bus_if.ioctl_index == 8'd1) begin
      if (bus_if.ioctl_addr < CART_LIM) begin
        hit_sel  = 3'b100;
        hit_addr = bus_if.ioctl_addr[16:0];
      end
    end
  end

  // Strobes outside IDLE arrive while wait is high and are ignored.
  assign accept = (state_q == ST_IDLE) && bus_if.ioctl_wr && bus_if.ioctl_download
                  && (hit_sel != 3'b000);

  always_comb begin
    state_d   = state_q;
    gap_cnt_d = gap_cnt_q;
    sel_d     = sel_q;
    addr_d    = addr_q;
    data_d    = data_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_EMIT;
          sel_d   = hit_sel;
          addr_d  = hit_addr;
          data_d  = bus_if.ioctl_dout;
        end
      end
      ST_EMIT: begin
        if (WR_GAP == 0) begin
          state_d = ST_IDLE;
        end else begin
          state_d   = ST_GAP;
          gap_cnt_d = GAP_LOAD;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == 4'd0) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign dl_rise = bus_if.ioctl_download && !dl_q;
  assign dl_fall = !bus_if.ioctl_download && dl_q;
  assign off_p1  = 18'(bus_if.ioctl_addr) + 18'd1;

  // Cart length tracking. The index is latched at the start of a download so
  // the commit on the falling edge does not depend on the index still being
  // held. A commit requested while a write is in EMIT waits one cycle so the
  // pending write retires first.
  always_comb begin
    acc_d         = acc_q;
    len_d         = len_q;
    loaded_d      = loaded_q;
    dl_cart_d     = dl_cart_q;
    commit_pend_d = commit_pend_q;
    if (dl_rise) begin
      dl_cart_d = (bus_if.ioctl_index == 8'd1);
      if (bus_if.ioctl_index == 8'd1) begin
        acc_d    = 18'd0;
        loaded_d = 1'b0;
      end
    end
    if (accept && hit_sel[2] && (off_p1 > acc_d)) begin
      acc_d = off_p1;
    end
    if (dl_fall && dl_cart_q) begin
      commit_pend_d = 1'b1;
    end
    if (commit_pend_d && (state_q != ST_EMIT)) begin
      len_d         = acc_d;
      loaded_d      = (acc_d != 18'd0);
      commit_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk_sys_i) begin
    if (reset_i) begin
      state_q       <= ST_IDLE;
      gap_cnt_q     <= 4'd0;
      sel_q         <= 3'b000;
      addr_q        <= 17'd0;
      data_q        <= 8'd0;
      acc_q         <= 18'd0;
      len_q         <= 18'd0;
      loaded_q      <= 1'b0;
      dl_q          <= 1'b0;
      dl_cart_q     <= 1'b0;
      commit_pend_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      gap_cnt_q     <= gap_cnt_d;
      sel_q         <= sel_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      acc_q         <= acc_d;
      len_q         <= len_d;
      loaded_q      <= loaded_d;
      dl_q          <= bus_if.ioctl_download;
      dl_cart_q     <= dl_cart_d;
      commit_pend_q <= commit_pend_d;
    end
  end

  assign bus_if.ioctl_wait       = (state_q != ST_IDLE);
  // Reset kills a write that is already sitting in EMIT.
  assign bus_if.rominit_valid    = (state_q == ST_EMIT) && !reset_i;
  assign bus_if.rominit_sel_boot = sel_q[0];
  assign bus_if.rominit_sel_chr  = sel_q[1];
  assign bus_if.rominit_sel_cart = sel_q[2];
  assign bus_if.rominit_addr     = addr_q;
  assign bus_if.rominit_data     = data_q;
  assign bus_if.cart_len         = len_q;
  assign bus_if.cart_loaded      = loaded_q;

endmodule

// File: tb/tb_rom_download_router.sv
// tb_rom_download_router
//   Drives download streams into rom_download_router and compares every
//   ROM-init write and the cart length status against a reference model.
module tb_rom_download_router;
  localparam int WR_GAP  = 2;
  localparam int SPACING = 2 + WR_GAP;

  typedef struct packed {
    logic [2:0]  sel;   // {cart, chr, boot}
    logic [16:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  always #5 clk_sys = ~clk_sys;

  rom_download_router_if bus_if ();

  rom_download_router #(.WR_GAP(WR_GAP)) dut (
    .clk_sys_i (clk_sys),
    .reset_i   (reset),
    .bus_if    (bus_if)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  wr_t         exp_q[$];
  wr_t         mon_got, mon_exp;
  int unsigned cart_max = 0;
  logic [17:0] exp_len = '0;
  logic        exp_loaded = 1'b0;
  int          cur_idx = 0;
  int          cyc = 0;
  int          last_valid_cyc = -1;
  bit          spacing_chk = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk_sys) cyc++;

  // Write monitor: every VALID pulse must match the oldest expected write.
  always @(negedge clk_sys) begin
    if (bus_if.rominit_valid === 1'b1) begin
      mon_got = {bus_if.rominit_sel_cart, bus_if.rominit_sel_chr, bus_if.rominit_sel_boot,
                 bus_if.rominit_addr, bus_if.rominit_data};
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'(mon_got), 32'hFFFF_FFFF);
      end else begin
        mon_exp = exp_q.pop_front();
        check("write", 32'(mon_got), 32'(mon_exp));
      end
      if (spacing_chk && last_valid_cyc >= 0)
        check("spacing", cyc - last_valid_cyc, SPACING);
      last_valid_cyc = cyc;
    end
  end

  // All tasks start and end just after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus_if.ioctl_wait !== 1'b0) begin
      @(posedge clk_sys); #1;
      n++;
      if (n > 50) begin
        check("wait_timeout", 1, 0);
        break;
      end
    end
  endtask

  // Reference decode straight from the address map.
  function automatic bit model_decode(input int idx, input int unsigned off,
                                      input logic [7:0] d, output wr_t e);
    e = '0;
    e.data = d;
    if (idx == 0 && off < 4096) begin
      e.sel = 3'b001; e.addr = 17'(off); return 1'b1;
    end
    if (idx == 0 && off < 4096 + 1024) begin
      e.sel = 3'b010; e.addr = 17'(off - 4096); return 1'b1;
    end
    if (idx == 1 && off < 131072) begin
      e.sel = 3'b100; e.addr = 17'(off % 131072); return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic send_byte(input int unsigned off, input logic [7:0] d);
    wr_t e;
    bit  hit;
    hit = model_decode(cur_idx, off, d, e);
    wait_ready();
    bus_if.ioctl_wr   = 1'b1;
    bus_if.ioctl_addr = 25'(off);
    bus_if.ioctl_dout = d;
    if (hit) begin
      exp_q.push_back(e);
      if (cur_idx == 1 && off + 1 > cart_max) cart_max = off + 1;
    end
    @(posedge clk_sys); #1;
    bus_if.ioctl_wr = 1'b0;
    check(hit ? "wait_after_accept" : "wait_after_drop", bus_if.ioctl_wait, hit);
  endtask

  task automatic start_download(input int idx);
    cur_idx = idx;
    bus_if.ioctl_index    = 8'(idx);
    bus_if.ioctl_download = 1'b1;
    if (idx == 1) begin
      cart_max   = 0;
      exp_loaded = 1'b0;
    end
    idle(1);
  endtask

  task automatic end_download();
    bus_if.ioctl_download = 1'b0;
    if (cur_idx == 1) begin
      exp_len    = 18'(cart_max);
      exp_loaded = (cart_max != 0);
    end
    idle(8);
    check("cart_len", bus_if.cart_len, exp_len);
    check("cart_loaded", bus_if.cart_loaded, exp_loaded);
    check("writes_drained", exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned last_pos, off;
    bus_if.ioctl_download = 1'b0;
    bus_if.ioctl_index    = 8'd0;
    bus_if.ioctl_wr       = 1'b0;
    bus_if.ioctl_addr     = '0;
    bus_if.ioctl_dout     = '0;

    repeat (3) @(posedge clk_sys);
    #1;
    check("rst_wait", bus_if.ioctl_wait, 0);
    check("rst_valid", bus_if.rominit_valid, 0);
    check("rst_sel", {bus_if.rominit_sel_cart, bus_if.rominit_sel_chr, bus_if.rominit_sel_boot}, 0);
    check("rst_addr", bus_if.rominit_addr, 0);
    check("rst_data", bus_if.rominit_data, 0);
    check("rst_cart_len", bus_if.cart_len, 0);
    check("rst_cart_loaded", bus_if.cart_loaded, 0);
    reset = 1'b0;
    idle(2);

    // Full boot pack, back to back, byte i = i[7:0].
    start_download(0);
    spacing_chk    = 1'b1;
    last_valid_cyc = -1;
    for (int i = 0; i < 5120; i++) send_byte(i, 8'(i));
    idle(1);
    spacing_chk = 1'b0;
    end_download();

    // Cartridge, sparse random offsets ending at 0x8FFF.
    start_download(1);
    last_pos = $urandom_range(0, 399);
    for (int i = 0; i < 400; i++) begin
      off = (i == last_pos) ? 32'h8FFF : $urandom_range(0, 32'h8FFE);
      send_byte(off, 8'($urandom));
    end
    end_download();
    check("cart_len_9000", bus_if.cart_len, 18'h9000);

    // Cartridge straddling capacity: top bytes dropped.
    start_download(1);
    check("loaded_cleared_on_start", bus_if.cart_loaded, 0);
    check("len_held_on_start", bus_if.cart_len, exp_len);
    for (int i = 0; i < 20; i++) send_byte($urandom_range(0, 32'h1000), 8'($urandom));
    for (int i = 32'h1FFF0; i < 32'h20010; i++) send_byte(i, 8'($urandom));
    end_download();
    check("cart_len_20000", bus_if.cart_len, 18'h20000);

    // Unrouted index and out-of-range boot-pack bytes.
    start_download(5);
    for (int i = 0; i < 20; i++) send_byte($urandom_range(0, 32'h3FFFF), 8'($urandom));
    end_download();
    start_download(0);
    for (int i = 0; i < 20; i++) send_byte($urandom_range(32'h1400, 32'h1FF_FFFF), 8'($urandom));
    end_download();

    // Strobe while wait is high is ignored.
    start_download(0);
    wait_ready();
    bus_if.ioctl_wr = 1'b1; bus_if.ioctl_addr = 25'h10; bus_if.ioctl_dout = 8'hA5;
    exp_q.push_back('{sel: 3'b001, addr: 17'h10, data: 8'hA5});
    idle(1);
    check("wait_before_violation", bus_if.ioctl_wait, 1);
    bus_if.ioctl_addr = 25'h20; bus_if.ioctl_dout = 8'h5A;
    idle(1);
    bus_if.ioctl_wr = 1'b0;
    send_byte(32'h1030, 8'h3C);
    end_download();

    // Random mix of downloads with boundary-biased offsets and idle gaps.
    for (int d = 0; d < 12; d++) begin
      int idx_pick;
      idx_pick = $urandom_range(0, 2);
      start_download(idx_pick == 2 ? 5 : idx_pick);
      for (int i = 0; i < 25; i++) begin
        case ($urandom_range(0, 7))
          0: off = 4095;
          1: off = 4096;
          2: off = 5119;
          3: off = 5120;
          4: off = 32'h1FFFF;
          5: off = 32'h20000;
          default: off = $urandom_range(0, 32'h21000);
        endcase
        send_byte(off, 8'($urandom));
        idle($urandom_range(0, 3));
      end
      end_download();
    end

    // Make sure a loaded cart exists, then reset right after an accepted strobe.
    start_download(1);
    send_byte(32'h123, 8'h11);
    end_download();
    check("loaded_before_reset", bus_if.cart_loaded, 1);
    start_download(1);
    wait_ready();
    bus_if.ioctl_wr = 1'b1; bus_if.ioctl_addr = 25'h100; bus_if.ioctl_dout = 8'h77;
    idle(1);
    bus_if.ioctl_wr       = 1'b0;
    bus_if.ioctl_download = 1'b0;
    reset                 = 1'b1;
    @(negedge clk_sys);
    check("reset_no_valid", bus_if.rominit_valid, 0);
    @(posedge clk_sys); #1;
    reset = 1'b0;
    exp_len    = '0;
    exp_loaded = 1'b0;
    check("reset_wait_low", bus_if.ioctl_wait, 0);
    check("reset_cart_len", bus_if.cart_len, exp_len);
    check("reset_cart_loaded", bus_if.cart_loaded, exp_loaded);
    idle(6);
    check("reset_no_late_write", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
